// File: rtl/result_buffer_2by2_pkg.sv
// Shared constants for the 2x2 result buffer: result indices, FSM states and
// the active-low 7-segment hex table.
package result_buffer_2by2_pkg;

  localparam logic [1:0] IDX_C11 = 2'd0;
  localparam logic [1:0] IDX_C21 = 2'd1;
  localparam logic [1:0] IDX_C12 = 2'd2;
  localparam logic [1:0] IDX_C22 = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, a lit segment is 0.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_HEX[nib];
  endfunction

endpackage

// File: rtl/result_buffer_2by2_seg7_hex_scan.sv
// Multiplexed 4-digit hex display driver: refresh counter, digit pointer and
// registered active-low digit enables / segments.
module seg7_hex_scan
  import result_buffer_2by2_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        blank,
  input  logic [15:0] value,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       digit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      digit <= '0;
      an    <= '1;
      seg   <= '1;
    end else begin
      if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
        cnt   <= '0;
        digit <= digit + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // Scanning keeps running while blanked so the phase is undisturbed.
      an  <= blank ? 4'b1111 : ~(4'b0001 << digit);
      seg <= hex_to_seg(value[4*digit +: 4]);
    end
  end

endmodule

// File: rtl/result_buffer_2by2.sv
// Captures the four 2x2 systolic results, serves them by read address with
// one cycle of latency, and shows the selected value on a 4-digit display.
module result_buffer_2by2
  import result_buffer_2by2_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              res_valid,
  input  logic [1:0]        res_idx,
  input  logic [DATA_W-1:0] res_data,
  input  logic [1:0]        buffer_read_addr_in,
  output logic [DATA_W-1:0] buffer_data_out,
  output logic              buffer_full,
  output logic              dup_err,
  output logic [3:0]        an,
  output logic [6:0]        seg
);

  state_t            state, state_nx;
  logic [DATA_W-1:0] entry [4];
  logic [3:0]        valid;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (clear) state_nx = FILL;
      FILL:    if (clear) state_nx = FILL;
               else if (&valid) state_nx = HOLD;
      HOLD:    if (clear) state_nx = FILL;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      valid           <= '0;
      dup_err         <= 1'b0;
      buffer_full     <= 1'b0;
      buffer_data_out <= '0;
      for (int unsigned i = 0; i < 4; i++) entry[i] <= '0;
    end else begin
      state       <= state_nx;
      buffer_full <= (state_nx == HOLD);
      // Read samples the pre-write contents, so a same-cycle write shows next cycle.
      buffer_data_out <= valid[buffer_read_addr_in] ? entry[buffer_read_addr_in] : '0;
      if (clear) begin
        valid   <= '0;
        dup_err <= 1'b0;
        for (int unsigned i = 0; i < 4; i++) entry[i] <= '0;
      end else if (state == FILL && res_valid) begin
        if (valid[res_idx]) begin
          dup_err <= 1'b1;
        end else begin
          entry[res_idx] <= res_data;
          valid[res_idx] <= 1'b1;
        end
      end
    end
  end

  seg7_hex_scan #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_scan (
    .clk   (clk),
    .rst   (rst),
    .blank (~buffer_full),
    .value (buffer_data_out[15:0]),
    .an    (an),
    .seg   (seg)
  );

endmodule

// File: tb/tb_result_buffer_2by2.sv
// Scoreboard bench for result_buffer_2by2: stimulus queues timed expectations,
// a negedge monitor retires and compares them.
module tb_result_buffer_2by2;

  localparam int K_DATA = 0, K_FULL = 1, K_DUP = 2, K_AN = 3, K_SEG = 4;

  typedef struct {
    int unsigned due;
    string       name;
    int          kind;
    logic [15:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        res_valid = 1'b0;
  logic [1:0]  res_idx = 2'd0;
  logic [15:0] res_data = 16'h0;
  logic [1:0]  rd_addr = 2'd0;
  logic [15:0] buffer_data_out;
  logic        buffer_full;
  logic        dup_err;
  logic [3:0]  an;
  logic [6:0]  seg;

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb [$];

  result_buffer_2by2 #(
    .DATA_W      (16),
    .REFRESH_DIV (4)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .clear               (clear),
    .res_valid           (res_valid),
    .res_idx             (res_idx),
    .res_data            (res_data),
    .buffer_read_addr_in (rd_addr),
    .buffer_data_out     (buffer_data_out),
    .buffer_full         (buffer_full),
    .dup_err             (dup_err),
    .an                  (an),
    .seg                 (seg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: retire every expectation due in the current cycle.
  always @(negedge clk) begin
    int unsigned i;
    logic [15:0] got;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        case (sb[i].kind)
          K_DATA:  got = buffer_data_out;
          K_FULL:  got = {15'd0, buffer_full};
          K_DUP:   got = {15'd0, dup_err};
          K_AN:    got = {12'd0, an};
          default: got = {9'd0, seg};
        endcase
        n_cmp++;
        if (got !== sb[i].val) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: got %h expected %h", sb[i].name, cyc, got, sb[i].val);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void expect_at(string nm, int kind, logic [15:0] val, int unsigned dly);
    exp_t e;
    e.due  = cyc + dly;
    e.name = nm;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endfunction

  task automatic wr(logic [1:0] idx, logic [15:0] d);
    res_valid = 1'b1;
    res_idx   = idx;
    res_data  = d;
    tick();
    res_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] rd_exp [4];
    logic [1:0]  rd_seq [4];
    logic [6:0]  seg_exp [4];
    logic [3:0]  prev_an;
    bit          found;

    rd_seq  = '{2'b00, 2'b10, 2'b01, 2'b11};
    rd_exp  = '{16'h1234, 16'h00AB, 16'hBEEF, 16'h0007};
    seg_exp = '{7'b0001110, 7'b0000110, 7'b0000110, 7'b0000011};

    // Reset
    repeat (3) tick();
    expect_at("rst_data", K_DATA, 16'h0000, 0);
    expect_at("rst_full", K_FULL, 16'h0, 0);
    expect_at("rst_dup",  K_DUP,  16'h0, 0);
    expect_at("rst_an",   K_AN,   16'h000F, 0);
    expect_at("rst_seg",  K_SEG,  16'h007F, 0);
    tick();
    rst = 1'b1;
    tick();

    // Fill and read
    clear = 1'b1; tick(); clear = 1'b0;
    res_valid = 1'b1;
    res_idx = 2'd0; res_data = 16'h1234; tick();
    res_idx = 2'd2; res_data = 16'h00AB; tick();
    res_idx = 2'd1; res_data = 16'hBEEF; tick();
    res_idx = 2'd3; res_data = 16'h0007;
    expect_at("full_lag", K_FULL, 16'h0, 1);
    expect_at("full_set", K_FULL, 16'h1, 2);
    tick();
    res_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      rd_addr = rd_seq[i];
      expect_at("fill_read", K_DATA, rd_exp[i], 1);
      tick();
    end
    expect_at("fill_dup", K_DUP, 16'h0, 0);

    // Display scan of 0xBEEF
    rd_addr = 2'b01;
    tick();
    found = 1'b0;
    prev_an = an;
    for (int t = 0; t < 64 && !found; t++) begin
      tick();
      if (an == 4'b1110 && prev_an == 4'b0111) found = 1'b1;
      prev_an = an;
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scan_sync: got no digit-0 entry, expected one within 64 cycles");
    end else begin
      for (int d = 0; d < 4; d++) begin
        for (int c = 0; c < 4; c++) begin
          expect_at("scan_an",  K_AN,  {12'd0, ~(4'b0001 << d)}, 4 * d + c);
          expect_at("scan_seg", K_SEG, {9'd0, seg_exp[d]},      4 * d + c);
        end
      end
      repeat (16) tick();
    end

    // HOLD ignores writes without raising an error
    res_valid = 1'b1; res_idx = 2'd1; res_data = 16'hFFFF;
    rd_addr = 2'b01;
    expect_at("hold_rd0", K_DATA, 16'hBEEF, 1);
    tick();
    res_valid = 1'b0;
    expect_at("hold_rd1", K_DATA, 16'hBEEF, 1);
    expect_at("hold_dup", K_DUP,  16'h0, 1);
    expect_at("hold_full", K_FULL, 16'h1, 1);
    tick();

    // Duplicate write in FILL
    clear = 1'b1; tick(); clear = 1'b0;
    wr(2'd0, 16'h1111);
    wr(2'd0, 16'h2222);
    expect_at("dup_set", K_DUP, 16'h1, 0);
    rd_addr = 2'b00;
    expect_at("dup_keep", K_DATA, 16'h1111, 1);
    tick();
    wr(2'd1, 16'hAAAA);
    wr(2'd2, 16'hBBBB);
    wr(2'd3, 16'hCCCC);
    tick();
    expect_at("dup_full", K_FULL, 16'h1, 0);
    expect_at("dup_sticky", K_DUP, 16'h1, 0);

    // clear collides with a write
    clear = 1'b1; res_valid = 1'b1; res_idx = 2'd0; res_data = 16'h5555;
    tick();
    clear = 1'b0; res_valid = 1'b0;
    expect_at("clr_full", K_FULL, 16'h0, 0);
    expect_at("clr_dup",  K_DUP,  16'h0, 0);
    rd_addr = 2'b00;
    expect_at("clr_rd0", K_DATA, 16'h0000, 1);
    tick();

    // Same-cycle write and read of one index
    res_valid = 1'b1; res_idx = 2'd2; res_data = 16'h4321;
    rd_addr = 2'b10;
    expect_at("wr_rd_old", K_DATA, 16'h0000, 1);
    expect_at("wr_rd_new", K_DATA, 16'h4321, 2);
    tick();
    res_valid = 1'b0;
    tick();
    tick();

    // Reset mid-fill, then writes without clear are ignored
    wr(2'd0, 16'h9999);
    wr(2'd1, 16'h8888);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    expect_at("mrst_data", K_DATA, 16'h0000, 0);
    expect_at("mrst_full", K_FULL, 16'h0, 0);
    expect_at("mrst_dup",  K_DUP,  16'h0, 0);
    expect_at("mrst_an",   K_AN,   16'h000F, 0);
    expect_at("mrst_seg",  K_SEG,  16'h007F, 0);
    rd_addr = 2'b00;
    wr(2'd0, 16'h7777);
    expect_at("idle_rd0",  K_DATA, 16'h0000, 1);
    expect_at("idle_full", K_FULL, 16'h0, 1);
    tick();
    tick();
    tick();

    while (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no check by cyc %0d, expected due cyc %0d", sb[0].name, cyc, sb[0].due);
      sb.delete(0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/result_buffer_2by2.md
Name: result_buffer_2by2

Overview:
- Downstream stage of the 2x2 systolic convolution controller.
- Captures the four 2x2 output-map results (C11, C12, C21, C22) from the systolic array into a small indexed buffer.
- Serves them by the controller's buffer_read_addr_in and drives a multiplexed 4-digit hex 7-segment display with the selected value.
- Board buttons step the controller through the read addresses; this block only stores, reads and displays.

Parameters:
- DATA_W, 16, result width; fixed at 4 hex digits, and only 16 is supported.
- REFRESH_DIV, 50000, clk cycles per displayed digit; must be >= 2.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-low.
- clear  in  1  one-cycle pulse at convolution start; empties the buffer.
- res_valid  in  1  systolic array result strobe.
- res_idx  in  2  result index: 00=C11, 01=C21, 10=C12, 11=C22.
- res_data  in  DATA_W  result value.
- buffer_read_addr_in  in  2  read address from the controller.
- buffer_data_out  out  DATA_W  registered read data.
- buffer_full  out  1  all four entries written.
- dup_err  out  1  sticky; set on a write to an already-written entry.
- an  out  4  digit enables, active-low, one-hot.
- seg  out  7  segments {g..a}, active-low.

Behaviour:
- All state changes on posedge clk. When rst=0 at an edge, every register resets:
  - state=IDLE, all entries 0, valid bits 0
  - buffer_data_out=0, buffer_full=0, dup_err=0
  - scan counter=0, digit pointer=0
  - an=4'b1111, seg=7'b1111111
- FSM:
  - IDLE: res_valid ignored. clear -> FILL.
  - FILL:
    - res_valid with valid[res_idx]=0: store res_data, set valid[res_idx].
    - res_valid with valid[res_idx]=1: keep the old data, set dup_err.
    - Next cycle after the 4th valid bit is set -> HOLD.
  - HOLD: buffer_full=1; res_valid ignored, with no error. clear -> FILL.
- clear in any state:
  - valid bits, entries, dup_err and buffer_full are all zeroed; state -> FILL.
  - clear and res_valid in the same cycle: clear wins and the write is dropped.
- buffer_full is registered. It is 1 exactly in HOLD, so it rises one cycle after the 4th write.
- Read path, 1-cycle latency:
  - buffer_data_out <= valid[addr] ? entry[addr] : 0, using buffer_read_addr_in sampled at the edge.
  - Updates every cycle in every state.
  - A write and a read to the same index in the same cycle returns the old value (0); the new value appears on the following cycle.
- Display scan:
  - Free-running counter 0..REFRESH_DIV-1. At wrap, the digit pointer advances 0->1->2->3->0.
  - Digit pointer d selects nibble buffer_data_out[4d+3:4d]; d=0 is the rightmost digit.
  - an[d]=0, others 1. seg = active-low hex decode (0-9, A-F) of the selected nibble, registered with an.
  - When buffer_full=0, an=4'b1111 (blank) while scanning continues.
  - Counter and pointer reset only on rst; clear does not reset them.
- Reset asserted mid-FILL discards partial results. Operation resumes only after the next clear.

Decomposition:
- Shared package / header:
  - result index constants IDX_C11=0, IDX_C21=1, IDX_C12=2, IDX_C22=3, matching the controller's read order 00,10,01,11
  - FSM state encodings IDLE=0, FILL=1, HOLD=2
  - 7-segment hex decode table constants
- One natural sub-module: seg7_hex_scan. It contains the refresh counter, digit pointer and hex decode, with inputs clk, rst, blank and value[15:0].
- The buffer, FSM and read register stay in the top.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> buffer_data_out=0, buffer_full=0, dup_err=0, an=1111, seg=1111111.
- Fill and read:
  - clear; write idx0=0x1234, idx2=0x00AB, idx1=0xBEEF, idx3=0x0007 on consecutive cycles -> buffer_full=1 one cycle after the last write.
  - Read addr 00,10,01,11 -> 0x1234, 0x00AB, 0xBEEF, 0x0007, each 1 cycle after the address.
- Duplicate and ignore:
  - In FILL, write idx0=0x1111 then idx0=0x2222 -> entry stays 0x1111, dup_err=1.
  - In HOLD, write idx1=0xFFFF -> read of idx1 unchanged, no new error.
- clear collision: clear with res_valid (idx0=0x5555) in the same cycle -> valid[0]=0, read idx0=0, buffer_full=0, dup_err cleared.
- Display, REFRESH_DIV=4, value 0xBEEF at addr 01, buffer_full=1:
  - an sequence 1110,1101,1011,0111, each held 4 cycles.
  - seg = decode F, E, E, B = 0001110, 0000110, 0000110, 0000011 (active-low {g..a}).
- Reset mid-fill: 2 writes, then rst=0 for 1 cycle -> all outputs at reset values; writes without clear are ignored (IDLE).
